proc_run_ctrl: RTL and testbench

Run sequencer for the processor system. It issues run requests to the processor, waits for the completion handshake on done, and enforces an inter-run gap. It counts completed runs and latches fault status, and mirrors that status onto LEDR. It sits between the board top level and the processor instance and replaces the tied-high run input.

---
 rtl/proc_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_proc_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - run sequencer: launch pulse, wait for done edge, inter-run gap
// Optional watchdog compiled in with PROC_RUN_CTRL_WATCHDOG_EN.
module proc_run_ctrl #(
    parameter int RUN_PULSE = 1,
    parameter int GAP       = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto,
    input  logic             abort,
    input  logic             done,
    output logic             run,
    output logic             busy,
    output logic [CNT_W-1:0] run_count,
    output logic             timeout_err,
    output logic [9:0]       ledr
);

    localparam int GAP_CYC = (GAP < 1) ? 1 : GAP;
    localparam int MAX_A   = (RUN_PULSE > GAP_CYC) ? RUN_PULSE : GAP_CYC;
    localparam int CYC_MAX = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int CW      = $clog2(CYC_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(RUN_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
`ifdef PROC_RUN_CTRL_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST    = CW'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cyc_cnt, cyc_d;
    logic              pending, pend_d;
    logic              done_q;
    logic [CNT_W-1:0]  count_d;
    logic              terr_d;
    logic              run_d, busy_d;
    logic [9:0]        ledr_d;
    logic [7:0]        cnt8;
    logic              rise;

    assign rise = done & ~done_q;

    generate
        if (CNT_W >= 8) begin : g_cnt_low
            assign cnt8 = count_d[7:0];
        end else begin : g_cnt_ext
            assign cnt8 = {{(8 - CNT_W){1'b0}}, count_d};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            pending     <= 1'b0;
            done_q      <= 1'b0;
            run_count   <= '0;
            timeout_err <= 1'b0;
            run         <= 1'b0;
            busy        <= 1'b0;
            ledr        <= '0;
        end else begin
            state       <= state_d;
            cyc_cnt     <= cyc_d;
            pending     <= pend_d;
            done_q      <= done;
            run_count   <= count_d;
            timeout_err <= terr_d;
            run         <= run_d;
            busy        <= busy_d;
            ledr        <= ledr_d;
        end
    end

    // cyc_cnt is a shared phase counter, zeroed on every state entry
    always_comb begin
        state_d = state;
        cyc_d   = '0;
        pend_d  = pending | (start && state != S_IDLE);
        count_d = run_count;
        terr_d  = timeout_err;
        case (state)
            S_IDLE: begin
                if (start || pending) begin
                    state_d = S_LAUNCH;
                    pend_d  = 1'b0;
                    if (start) terr_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (cyc_cnt == PULSE_LAST) state_d = S_WAIT;
                else                       cyc_d   = cyc_cnt + CW'(1);
            end
            S_WAIT: begin
                if (rise) begin
                    state_d = S_GAP;
                    count_d = run_count + CNT_W'(1);
                end
`ifdef PROC_RUN_CTRL_WATCHDOG_EN
                else if (cyc_cnt == WD_LAST) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    cyc_d = cyc_cnt + CW'(1);
                end
`endif
            end
            S_GAP: begin
                if (cyc_cnt == GAP_LAST) begin
                    if (auto || pending) begin
                        state_d = S_LAUNCH;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_cnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort overrides everything, including a same-cycle start or done edge
        if (abort) begin
            state_d = S_IDLE;
            cyc_d   = '0;
            pend_d  = 1'b0;
            count_d = run_count;
            terr_d  = timeout_err;
        end
    end

    always_comb begin
        run_d  = (state_d == S_LAUNCH);
        busy_d = (state_d != S_IDLE);
        ledr_d = {terr_d, busy_d, cnt8};
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb/tb_proc_run_ctrl.sv - randomized self-checking bench for proc_run_ctrl
// Watchdog scenario compiled in with PROC_RUN_CTRL_WATCHDOG_EN.
module tb_proc_run_ctrl;
    localparam int RP = 1;
    localparam int GP = 4;
    localparam int TO = 16;
    localparam int CW = 4;
    localparam int G  = (GP < 1) ? 1 : GP;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          auto_m = 1'b0;
    logic          abort = 1'b0;
    logic          done = 1'b0;
    logic          run, busy, timeout_err;
    logic [CW-1:0] run_count;
    logic [9:0]    ledr;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    proc_run_ctrl #(.RUN_PULSE(RP), .GAP(GP), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .auto(auto_m), .abort(abort),
        .done(done), .run(run), .busy(busy), .run_count(run_count),
        .timeout_err(timeout_err), .ledr(ledr)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1; step(1); done = 1'b0;
    endtask

    function automatic int exp_cnt();
        return exp_count % (1 << CW);
    endfunction

    function automatic logic [9:0] exp_ledr(input logic b, input logic t);
        logic [7:0] c;
        c = 8'(exp_cnt());
        return {t, b, c};
    endfunction

    task automatic test_reset();
        reset = 1'b1; step(2); reset = 1'b0; step(1);
        checks++; if ({run, busy, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: run/busy/terr=%b expected 000", {run, busy, timeout_err}); end
        checks++; if (run_count !== '0 || ledr !== 10'h000) begin errors++; $display("FAIL reset_values: count=%0d ledr=%h expected 0/000", run_count, ledr); end
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_prestart: busy=%b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({run, busy} !== 2'b00) begin errors++; $display("FAIL reset_async: run/busy=%b expected 00", {run, busy}); end
        reset = 1'b0;
        exp_count = 0;
        step(1);
    endtask

    task automatic test_single_run();
        int d;
        d = $urandom_range(2, 10);
        pulse_start();
        for (int i = 0; i < RP; i++) begin
            checks++; if (run !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_launch: run/busy=%b%b expected 11", run, busy); end
            step(1);
        end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL single_run_width: run=%b expected 0", run); end
        step(d - 1);
        checks++; if (run_count !== CW'(exp_cnt()) || busy !== 1'b1) begin errors++; $display("FAIL single_wait: count=%0d busy=%b expected %0d/1", run_count, busy, exp_cnt()); end
        pulse_done();
        exp_count++;
        checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL single_count: count=%0d expected %0d", run_count, exp_cnt()); end
        checks++; if (ledr !== exp_ledr(1'b1, 1'b0)) begin errors++; $display("FAIL single_ledr_busy: ledr=%h expected %h", ledr, exp_ledr(1'b1, 1'b0)); end
        step(G - 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap: busy=%b expected 1", busy); end
        step(1);
        checks++; if (busy !== 1'b0 || ledr !== exp_ledr(1'b0, 1'b0)) begin errors++; $display("FAIL single_idle: busy=%b ledr=%h expected 0/%h", busy, ledr, exp_ledr(1'b0, 1'b0)); end
    endtask

    task automatic test_auto();
        int k;
        auto_m = 1'b1;
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < RP; i++) begin
                checks++; if (run !== 1'b1) begin errors++; $display("FAIL auto_launch: run=%b expected 1 (run %0d)", run, r); end
                step(1);
            end
            step($urandom_range(0, 6));
            pulse_done();
            exp_count++;
            checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL auto_count: count=%0d expected %0d", run_count, exp_cnt()); end
            if (r == 2) auto_m = 1'b0;
            else begin
                k = 0;
                while (run !== 1'b1 && k < 3 * G + 5) begin step(1); k++; end
                checks++; if (k != G) begin errors++; $display("FAIL auto_relaunch: cycles=%0d expected %0d", k, G); end
            end
        end
        step(G);
        checks++; if ({run, busy} !== 2'b00) begin errors++; $display("FAIL auto_stop: run/busy=%b expected 00", {run, busy}); end
    endtask

    task automatic test_pending();
        int k;
        logic seen;
        pulse_start();
        step(RP + $urandom_range(0, 3));
        pulse_start();
        step($urandom_range(0, 3));
        pulse_start();
        step($urandom_range(0, 3));
        pulse_done();
        exp_count++;
        checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL pend_count1: count=%0d expected %0d", run_count, exp_cnt()); end
        k = 0;
        while (run !== 1'b1 && k < 3 * G + 5) begin step(1); k++; end
        checks++; if (k != G) begin errors++; $display("FAIL pend_relaunch: cycles=%0d expected %0d", k, G); end
        step(RP + $urandom_range(0, 3));
        pulse_done();
        exp_count++;
        checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL pend_count2: count=%0d expected %0d", run_count, exp_cnt()); end
        step(G);
        seen = 1'b0;
        repeat (G + 4) begin
            if (run !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step(1);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL pend_single_extra: extra activity=%b expected 0", seen); end
    endtask

    task automatic test_stale_done();
        start = 1'b1; step(1); start = 1'b0;
        done = 1'b1;
        step(RP);
        step($urandom_range(2, 6));
        checks++; if (run_count !== CW'(exp_cnt()) || busy !== 1'b1) begin errors++; $display("FAIL stale_held: count=%0d busy=%b expected %0d/1", run_count, busy, exp_cnt()); end
        done = 1'b0;
        step($urandom_range(1, 3));
        checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL stale_fall: count=%0d expected %0d", run_count, exp_cnt()); end
        pulse_done();
        exp_count++;
        checks++; if (run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL stale_fresh_edge: count=%0d expected %0d", run_count, exp_cnt()); end
        step(G);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_abort();
        logic seen;
        pulse_start();
        step(RP + $urandom_range(0, 3));
        pulse_start();
        step($urandom_range(0, 2));
        abort = 1'b1; start = 1'b1;
        step(1);
        abort = 1'b0; start = 1'b0;
        checks++; if ({run, busy} !== 2'b00) begin errors++; $display("FAIL abort_idle: run/busy=%b expected 00", {run, busy}); end
        checks++; if (run_count !== CW'(exp_cnt()) || ledr !== exp_ledr(1'b0, 1'b0)) begin errors++; $display("FAIL abort_status: count=%0d ledr=%h expected %0d/%h", run_count, ledr, exp_cnt(), exp_ledr(1'b0, 1'b0)); end
        seen = 1'b0;
        repeat (G + 6) begin
            step(1);
            if (run !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_relaunch: activity=%b expected 0", seen); end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        do begin
            if (exp_cnt() == (1 << CW) - 1) begin
                checks++; if (run_count !== CW'((1 << CW) - 1)) begin errors++; $display("FAIL wrap_max: count=%0d expected %0d", run_count, (1 << CW) - 1); end
            end
            pulse_start();
            step(RP + $urandom_range(0, 2));
            pulse_done();
            exp_count++;
            step(G);
            n++;
        end while (exp_cnt() != 0 && n < 40);
        checks++; if (run_count !== '0 || ledr[7:0] !== 8'h00) begin errors++; $display("FAIL wrap_zero: count=%0d ledr=%h expected 0/00", run_count, ledr[7:0]); end
    endtask

`ifdef PROC_RUN_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        auto_m = 1'b1;
        pulse_start();
        step(RP);
        step(TO - 1);
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_before: busy=%b terr=%b expected 1/0", busy, timeout_err); end
        step(1);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL wd_fire: busy=%b terr=%b expected 0/1", busy, timeout_err); end
        checks++; if (ledr !== exp_ledr(1'b0, 1'b1)) begin errors++; $display("FAIL wd_ledr: ledr=%h expected %h", ledr, exp_ledr(1'b0, 1'b1)); end
        auto_m = 1'b0;
        step(2);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: busy=%b terr=%b expected 0/1", busy, timeout_err); end
        pulse_start();
        checks++; if (timeout_err !== 1'b0 || run !== 1'b1) begin errors++; $display("FAIL wd_clear: terr=%b run=%b expected 0/1", timeout_err, run); end
        step(RP);
        pulse_done();
        exp_count++;
        step(G);
    endtask
`else
    task automatic test_no_watchdog();
        pulse_start();
        step(RP + 2 * TO + 5);
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL nowd_hold: busy=%b terr=%b expected 1/0", busy, timeout_err); end
        abort = 1'b1; step(1); abort = 1'b0;
        checks++; if (busy !== 1'b0 || run_count !== CW'(exp_cnt())) begin errors++; $display("FAIL nowd_abort: busy=%b count=%0d expected 0/%0d", busy, run_count, exp_cnt()); end
    endtask
`endif

    initial begin
        test_reset();
        repeat (3) test_single_run();
        test_auto();
        test_pending();
        test_stale_done();
        test_abort();
        test_wrap();
`ifdef PROC_RUN_CTRL_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
